// File: rtl/ext_fifo_onchip_if.sv
// Write/read handshake bundle and status for ext_fifo_onchip.
// slave = the FIFO, master = producer/consumer side.
interface ext_fifo_onchip_if #(
  parameter int INT_WIDTH  = 36,
  parameter int FIFO_DEPTH = 9
);
  logic [INT_WIDTH-1:0]  datain;
  logic                  src_rdy_i;
  logic                  dst_rdy_o;
  logic [INT_WIDTH-1:0]  dataout;
  logic                  src_rdy_o;
  logic                  dst_rdy_i;
  logic [FIFO_DEPTH:0]   occupied;
  logic [FIFO_DEPTH:0]   space;
  logic                  almost_full;

  modport master (
    output datain, src_rdy_i, dst_rdy_i,
    input  dst_rdy_o, dataout, src_rdy_o,
    input  occupied, space, almost_full
  );

  modport slave (
    input  datain, src_rdy_i, dst_rdy_i,
    output dst_rdy_o, dataout, src_rdy_o,
    output occupied, space, almost_full
  );
endinterface

// File: rtl/ext_fifo_onchip.sv
// Slice/repack FIFO in on-chip RAM with hysteretic almost_full.
// EXT_FIFO_REFILL_SPREAD_EN: LFSR-delayed almost_full release.
module ext_fifo_onchip #(
  parameter int INT_WIDTH  = 36,
  parameter int EXT_WIDTH  = 18,
  parameter int FIFO_DEPTH = 9,
  parameter int AF_THRESH  = 448,
  parameter int AF_HYST    = 64
) (
  input logic              clk,
  input logic              rst,
  input logic              clear,
  ext_fifo_onchip_if.slave bus
);
  localparam int RATIO = INT_WIDTH / EXT_WIDTH;

  generate
    if (RATIO * EXT_WIDTH != INT_WIDTH ||
        !(RATIO == 1 || RATIO == 2 || RATIO == 4))
    begin : g_bad_ratio
      $error("INT_WIDTH/EXT_WIDTH must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [2:0] RATIO_C = 3'(RATIO);
  localparam logic [FIFO_DEPTH:0] FULL_C =
    {1'b1, {FIFO_DEPTH{1'b0}}};
  localparam logic [FIFO_DEPTH:0] AF_SET =
    AF_THRESH[FIFO_DEPTH:0];
  localparam logic [FIFO_DEPTH:0] AF_CLR =
    AF_SET - AF_HYST[FIFO_DEPTH:0];

  logic                  flush;
  logic [EXT_WIDTH-1:0]  mem [2**FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] wr_ptr;
  logic [FIFO_DEPTH-1:0] rd_ptr;
  logic [FIFO_DEPTH:0]   occ;
  logic [INT_WIDTH-1:0]  sp_word;
  logic [INT_WIDTH-1:0]  pk_word;
  logic [2:0]            sp_cnt;
  logic [2:0]            pk_cnt;
  logic                  af;
  logic                  ram_wr;
  logic                  ram_rd;
  logic                  pk_full;
  logic                  give;
  logic                  take;

  assign flush   = rst | clear;
  assign ram_wr  = (sp_cnt != '0) && (occ != FULL_C);
  assign pk_full = (pk_cnt == RATIO_C);
  assign give    = pk_full && bus.dst_rdy_i;
  assign ram_rd  = (occ != '0) &&
                   (!pk_full || bus.dst_rdy_i);
  assign bus.dst_rdy_o = !flush &&
    ((sp_cnt == '0) || (sp_cnt == 3'd1 && ram_wr));
  assign take = bus.src_rdy_i && bus.dst_rdy_o;

  assign bus.dataout     = pk_word;
  assign bus.src_rdy_o   = pk_full;
  assign bus.occupied    = occ;
  assign bus.space       = FULL_C - occ;
  assign bus.almost_full = af;

  // Splitter shifts left so the MS slice is always on top.
  always_ff @(posedge clk) begin
    if (flush) begin
      sp_word <= '0;
      sp_cnt  <= '0;
    end else if (take) begin
      sp_word <= bus.datain;
      sp_cnt  <= RATIO_C;
    end else if (ram_wr) begin
      sp_word <= sp_word << EXT_WIDTH;
      sp_cnt  <= sp_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr && !flush)
      mem[wr_ptr] <= sp_word[INT_WIDTH-1 -: EXT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (ram_wr) wr_ptr <= wr_ptr + FIFO_DEPTH'(1);
      if (ram_rd) rd_ptr <= rd_ptr + FIFO_DEPTH'(1);
      unique case (1'b1)
        ram_wr && !ram_rd:
          occ <= occ + (FIFO_DEPTH+1)'(1);
        ram_rd && !ram_wr:
          occ <= occ - (FIFO_DEPTH+1)'(1);
        default: ;
      endcase
    end
  end

  // RAM read lands straight in the assembly register.
  always_ff @(posedge clk) begin
    if (flush) begin
      pk_word <= '0;
      pk_cnt  <= '0;
    end else if (ram_rd) begin
      pk_word <= (pk_word << EXT_WIDTH) |
                 INT_WIDTH'(mem[rd_ptr]);
      pk_cnt  <= give ? 3'd1 : pk_cnt + 3'd1;
    end else if (give) begin
      pk_cnt <= '0;
    end
  end

`ifdef EXT_FIFO_REFILL_SPREAD_EN
  logic [6:0] lfsr;
  logic [6:0] wait_cnt;
  logic       waiting;

  always_ff @(posedge clk) begin
    if (flush) begin
      lfsr     <= 7'h01;
      af       <= 1'b0;
      waiting  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      if (occ >= AF_SET) begin
        af      <= 1'b1;
        waiting <= 1'b0;
      end else if (af && occ <= AF_CLR) begin
        if (waiting) begin
          if (wait_cnt == 7'd1) begin
            af      <= 1'b0;
            waiting <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 7'd1;
          end
        end else if (lfsr == '0) begin
          af <= 1'b0;
        end else begin
          waiting  <= 1'b1;
          wait_cnt <= lfsr;
        end
      end else begin
        waiting <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (flush)
      af <= 1'b0;
    else if (occ >= AF_SET)
      af <= 1'b1;
    else if (occ <= AF_CLR)
      af <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_ext_fifo_onchip.sv
// Randomised bench for ext_fifo_onchip against a slice-queue model.
// Directed literal checks pin latency, capacity and hysteresis.
module tb_ext_fifo_onchip;
  localparam int IW  = 36;
  localparam int EW  = 18;
  localparam int R   = 2;
  localparam int DW  = 4;
  localparam int DEP = 16;
  localparam int TH  = 12;
  localparam int HY  = 4;

  logic clk;
  logic rst;
  logic clear;
  int   n_chk;
  int   n_fail;

  ext_fifo_onchip_if #(.INT_WIDTH(IW), .FIFO_DEPTH(DW)) bus ();

  ext_fifo_onchip #(
    .INT_WIDTH(IW), .EXT_WIDTH(EW), .FIFO_DEPTH(DW),
    .AF_THRESH(TH), .AF_HYST(HY)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [EW-1:0] m_sp[$];
  logic [EW-1:0] m_ram[$];
  logic [EW-1:0] m_pk[$];
  logic [IW-1:0] m_sb[$];
  logic          m_af;
  int            m_cyc;
`ifdef EXT_FIFO_REFILL_SPREAD_EN
  logic [6:0]    m_lfsr;
  logic          m_streak;
  int            m_deadline;
`endif

  initial begin
    m_af  = 1'b0;
    m_cyc = 0;
`ifdef EXT_FIFO_REFILL_SPREAD_EN
    m_lfsr     = 7'h01;
    m_streak   = 1'b0;
    m_deadline = 0;
`endif
  end

  // Model: three slice queues (splitter, RAM, packer) plus a
  // word scoreboard; evaluated mid-cycle, then advanced.
  always @(negedge clk) begin : model
    logic          fl;
    logic          wr;
    logic          rd;
    logic          pop;
    logic          ok;
    logic [IW-1:0] pd;
    int            occ;
    fl  = rst || clear;
    occ = m_ram.size();
    wr  = (m_sp.size() > 0) && (occ < DEP);
    rd  = (occ > 0) &&
          ((m_pk.size() < R) || bus.dst_rdy_i);
    pop = (m_pk.size() == R) && bus.dst_rdy_i;
    ok  = !fl && ((m_sp.size() == 0) ||
                  (m_sp.size() == 1 && wr));
    chk("dst_rdy_o", 64'(bus.dst_rdy_o), 64'(ok));
    chk("src_rdy_o", 64'(bus.src_rdy_o),
        64'(m_pk.size() == R));
    chk("occupied", 64'(bus.occupied), 64'(occ));
    chk("space", 64'(bus.space), 64'(DEP - occ));
    chk("almost_full", 64'(bus.almost_full), 64'(m_af));
    if (m_pk.size() == R) begin
      pd = '0;
      foreach (m_pk[i]) pd = (pd << EW) | IW'(m_pk[i]);
      chk("dataout", 64'(bus.dataout), 64'(pd));
    end
    if (pop && !fl) begin
      if (m_sb.size() > 0)
        chk("sb_order", 64'(bus.dataout),
            64'(m_sb.pop_front()));
      else
        chk("sb_empty_pop", 64'(1), 64'(0));
    end
    if (fl) begin
      m_sp.delete();
      m_ram.delete();
      m_pk.delete();
      m_sb.delete();
      m_af = 1'b0;
`ifdef EXT_FIFO_REFILL_SPREAD_EN
      m_lfsr   = 7'h01;
      m_streak = 1'b0;
`endif
    end else begin
      if (occ >= TH) begin
        m_af = 1'b1;
`ifdef EXT_FIFO_REFILL_SPREAD_EN
        m_streak = 1'b0;
`endif
      end else if (m_af && occ <= TH - HY) begin
`ifdef EXT_FIFO_REFILL_SPREAD_EN
        if (!m_streak) begin
          m_streak   = 1'b1;
          m_deadline = m_cyc + int'(m_lfsr);
        end
        if (m_cyc == m_deadline) begin
          m_af     = 1'b0;
          m_streak = 1'b0;
        end
`else
        m_af = 1'b0;
`endif
      end else begin
`ifdef EXT_FIFO_REFILL_SPREAD_EN
        m_streak = 1'b0;
`endif
      end
`ifdef EXT_FIFO_REFILL_SPREAD_EN
      m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
`endif
      if (pop) m_pk.delete();
      if (rd) m_pk.push_back(m_ram.pop_front());
      if (wr) m_ram.push_back(m_sp.pop_front());
      if (bus.src_rdy_i && ok) begin
        m_sb.push_back(bus.datain);
        for (int i = R - 1; i >= 0; i--)
          m_sp.push_back(bus.datain[i*EW +: EW]);
      end
    end
    m_cyc++;
  end

  task automatic cyc_in(input logic s,
                        input logic [IW-1:0] d,
                        input logic dr,
                        input logic c);
    @(posedge clk);
    #2;
    bus.src_rdy_i = s;
    bus.datain    = d;
    bus.dst_rdy_i = dr;
    clear         = c;
    #1;
  endtask

  task automatic wait_word(input string nm,
                           input logic [IW-1:0] w);
    int lat;
    logic [IW-1:0] got;
    lat = 0;
    got = '0;
    for (int k = 1; k <= 8; k++) begin
      cyc_in(1'b0, '0, 1'b1, 1'b0);
      if (bus.src_rdy_o && lat == 0) begin
        lat = k;
        got = bus.dataout;
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(4));
    chk({nm, "_data"}, 64'(got), 64'(w));
  endtask

  initial begin : stim
    int            acc;
    int            pops;
    int            fall_at;
    int            nval;
    logic          pend;
    logic          rise_done;
    logic          seen9;
    logic          seen8;
    logic          fall_done;
    logic [IW-1:0] nw;
    logic [63:0]   rr;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    clear  = 1'b0;
    bus.src_rdy_i = 1'b1;
    bus.datain    = 36'h1_1111_1111;
    bus.dst_rdy_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("rst_dst_rdy", 64'(bus.dst_rdy_o), 64'(0));
    chk("rst_src_rdy", 64'(bus.src_rdy_o), 64'(0));
    chk("rst_dataout", 64'(bus.dataout), 64'(0));
    chk("rst_occupied", 64'(bus.occupied), 64'(0));
    chk("rst_space", 64'(bus.space), 64'(16));
    chk("rst_af", 64'(bus.almost_full), 64'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.src_rdy_i = 1'b0;
    #1;
    chk("post_rst_dst_rdy", 64'(bus.dst_rdy_o), 64'(1));
    chk("post_rst_occ", 64'(bus.occupied), 64'(0));

    cyc_in(1'b1, 36'hA_BCDE_F012, 1'b1, 1'b0);
    chk("lat_accept", 64'(bus.dst_rdy_o), 64'(1));
    wait_word("lat", 36'hA_BCDE_F012);

    acc       = 0;
    pend      = 1'b0;
    rise_done = 1'b0;
    nw        = 36'h9_8765_0000;
    for (int k = 0; k < 40; k++) begin
      cyc_in(1'b1, nw, 1'b0, 1'b0);
      if (bus.dst_rdy_o) begin
        acc++;
        nw = nw + 36'd1;
      end
      if (pend && !rise_done) begin
        chk("af_rise", 64'(bus.almost_full), 64'(1));
        rise_done = 1'b1;
      end
      if (!pend && bus.occupied == 5'd12) begin
        chk("af_below", 64'(bus.almost_full), 64'(0));
        pend = 1'b1;
      end
    end
    chk("full_words", 64'(acc), 64'(10));
    chk("full_dst_rdy", 64'(bus.dst_rdy_o), 64'(0));
    chk("full_occupied", 64'(bus.occupied), 64'(16));
    chk("full_space", 64'(bus.space), 64'(0));
    chk("full_src_rdy", 64'(bus.src_rdy_o), 64'(1));
    chk("af_rise_seen", 64'(rise_done), 64'(1));

    pops      = 0;
    seen9     = 1'b0;
    seen8     = 1'b0;
    fall_done = 1'b0;
    fall_at   = 0;
    for (int k = 0; k < 250; k++) begin
      cyc_in(1'b0, '0, 1'b1, 1'b0);
      if (bus.src_rdy_o) begin
        chk("drain_order", 64'(bus.dataout),
            64'(36'h9_8765_0000 + IW'(pops)));
        pops++;
      end
      if (!seen9 && bus.occupied == 5'd9) begin
        chk("af_hold9", 64'(bus.almost_full), 64'(1));
        seen9 = 1'b1;
      end
      if (!seen8 && bus.occupied == 5'd8) begin
        chk("af_at8", 64'(bus.almost_full), 64'(1));
        seen8 = 1'b1;
`ifdef EXT_FIFO_REFILL_SPREAD_EN
        nval = int'(m_lfsr);
`else
        nval = 0;
`endif
        fall_at = k + 1 + nval;
      end
      if (seen8 && !fall_done) begin
        if (k == fall_at - 1)
          chk("af_pre_fall", 64'(bus.almost_full), 64'(1));
        if (k == fall_at) begin
          chk("af_fall", 64'(bus.almost_full), 64'(0));
          fall_done = 1'b1;
        end
      end
      if (pops == 10 && fall_done) break;
    end
    chk("drain_count", 64'(pops), 64'(10));
    chk("af_fall_seen", 64'(fall_done), 64'(1));

    cyc_in(1'b1, 36'hC_0FFE_E123, 1'b0, 1'b0);
    chk("clr_acc1", 64'(bus.dst_rdy_o), 64'(1));
    cyc_in(1'b0, '0, 1'b0, 1'b0);
    cyc_in(1'b1, 36'hD_1234_5678, 1'b0, 1'b0);
    chk("clr_acc2", 64'(bus.dst_rdy_o), 64'(1));
    cyc_in(1'b0, '0, 1'b0, 1'b1);
    chk("clr_occ_before", 64'(bus.occupied), 64'(1));
    cyc_in(1'b0, '0, 1'b0, 1'b0);
    chk("clr_occupied", 64'(bus.occupied), 64'(0));
    chk("clr_src_rdy", 64'(bus.src_rdy_o), 64'(0));
    chk("clr_dst_rdy", 64'(bus.dst_rdy_o), 64'(1));
    cyc_in(1'b1, 36'h1_2345_6789, 1'b1, 1'b0);
    wait_word("clr_word", 36'h1_2345_6789);

    for (int k = 0; k < 2500; k++) begin
      rr = {$urandom(), $urandom()};
      cyc_in($urandom_range(0, 3) != 0, rr[IW-1:0],
             (k < 1250) ? ($urandom_range(0, 2) == 0)
                        : ($urandom_range(0, 2) != 0),
             $urandom_range(0, 299) == 0);
    end
    for (int k = 0; k < 100; k++)
      cyc_in(1'b0, '0, 1'b1, 1'b0);
    chk("final_occupied", 64'(bus.occupied), 64'(0));
    chk("final_sb_empty", 64'(m_sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
